// File: rtl/n_clic_pipe_if.sv
// CSR bus and PC-redirect bundle between the core and the interrupt controller.
// The core (CSR file / PC mux) is the master; the controller is the slave.
interface n_clic_pipe_if #(
  parameter int NumIrq    = 16,
  parameter int PrioWidth = 4,
  parameter int AddrWidth = 32
);
  localparam int IdWidth = $clog2(NumIrq);

  logic                 csr_we;
  logic [11:0]          csr_addr;
  logic [31:0]          csr_wdata;
  logic [31:0]          csr_rdata;
  logic [AddrWidth-1:0] pc_in;
  logic                 ret_i;
  logic                 int_valid;
  logic [AddrWidth-1:0] int_addr;
  logic [IdWidth-1:0]   int_id;
  logic [PrioWidth-1:0] int_prio;
  logic                 tail_chain;

  modport master (
    output csr_we, csr_addr, csr_wdata, pc_in, ret_i,
    input  csr_rdata, int_valid, int_addr, int_id, int_prio, tail_chain
  );

  modport slave (
    input  csr_we, csr_addr, csr_wdata, pc_in, ret_i,
    output csr_rdata, int_valid, int_addr, int_id, int_prio, tail_chain
  );
endinterface

// File: rtl/n_clic_pipe.sv
// Pipelined core-local interrupt controller.
// Stage 1 scans enabled+pended entries for the highest priority (lowest index
// wins ties) and registers the winner. Stage 2 re-qualifies that candidate
// against the live pend/enable state and decides take / tail-chain / return.
// Nesting is tracked on a bounded stack of {return PC, saved threshold}.
module n_clic_pipe #(
  parameter int          NumIrq     = 16,
  parameter int          PrioWidth  = 4,
  parameter int          NumLevels  = 8,
  parameter int          AddrWidth  = 32,
  parameter logic [11:0] EntryBase  = 12'hB00,
  parameter logic [11:0] VecBase    = 12'hB40,
  parameter logic [11:0] ThreshAddr = 12'h347,
  parameter logic [11:0] LevelAddr  = 12'h350
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NumIrq-1:0]                irq_i,
  input  logic                             mie,
  n_clic_pipe_if.slave                     bus,
  output logic [$clog2(NumLevels+1)-1:0]   level_out,
  output logic                             stack_err
);
  localparam int IdW  = $clog2(NumIrq);
  localparam int LvW  = $clog2(NumLevels + 1);
  localparam int PtrW = (NumLevels > 1) ? $clog2(NumLevels) : 1;

  // Per-entry configuration and pend state
  logic [NumIrq-1:0]    pend_reg, en_reg, trig_reg, irq_q_reg;
  logic [PrioWidth-1:0] prio_reg [NumIrq];
  logic [31:0]          vec_reg  [NumIrq];

  // Controller state
  logic [PrioWidth-1:0] thresh_reg;
  logic [AddrWidth-1:0] stk_pc_reg [NumLevels];
  logic [PrioWidth-1:0] stk_th_reg [NumLevels];
  logic [LvW-1:0]       level_reg;
  logic                 stack_err_reg;

  // Registered stage-1 result
  logic                 cand_valid_reg;
  logic [IdW-1:0]       cand_id_reg;
  logic [PrioWidth-1:0] cand_prio_reg;

  logic                 scan_found;
  logic [IdW-1:0]       scan_id;
  logic [PrioWidth-1:0] scan_prio;

  logic [NumIrq-1:0]    entry_we, vec_we, hw_set, take_clr, pend_next;
  logic                 thresh_we;
  logic                 cand_qual, stack_empty, stack_full;
  logic                 act_take, act_tail, act_pop, act_err;
  logic [PtrW-1:0]      top_idx, push_idx;
  logic [PrioWidth-1:0] top_th;
  logic [AddrWidth-1:0] top_pc;
  logic [33:0]          vec_word;
  logic [AddrWidth-1:0] handler_addr;

  assign thresh_we = bus.csr_we && (bus.csr_addr == ThreshAddr);

  // Per-entry CSR decode and pend update: a hardware set overrides both a CSR
  // write of 0 and the clear caused by entering this vector.
  for (genvar gi = 0; gi < NumIrq; gi++) begin : g_entry
    assign entry_we[gi]  = bus.csr_we && (bus.csr_addr == EntryBase + 12'(gi));
    assign vec_we[gi]    = bus.csr_we && (bus.csr_addr == VecBase + 12'(gi));
    assign hw_set[gi]    = trig_reg[gi] ? (irq_i[gi] & ~irq_q_reg[gi]) : irq_i[gi];
    assign take_clr[gi]  = (act_take || act_tail) && (cand_id_reg == IdW'(gi));
    assign pend_next[gi] = hw_set[gi] |
                           (~take_clr[gi] & (entry_we[gi] ? bus.csr_wdata[0] : pend_reg[gi]));
  end

  // Stage 1: priority scan over enabled+pended entries, lowest index on ties
  always_comb begin
    scan_found = 1'b0;
    scan_id    = '0;
    scan_prio  = '0;
    for (int i = 0; i < NumIrq; i++) begin
      if (en_reg[i] && pend_reg[i] && (!scan_found || prio_reg[i] > scan_prio)) begin
        scan_found = 1'b1;
        scan_id    = IdW'(i);
        scan_prio  = prio_reg[i];
      end
    end
  end

  assign top_idx      = PtrW'(level_reg - LvW'(1));
  assign push_idx     = PtrW'(level_reg);
  assign top_th       = stk_th_reg[top_idx];
  assign top_pc       = stk_pc_reg[top_idx];
  assign stack_empty  = (level_reg == '0);
  assign stack_full   = (level_reg == LvW'(NumLevels));
  assign cand_qual    = cand_valid_reg && en_reg[cand_id_reg] && pend_reg[cand_id_reg];
  assign vec_word     = {vec_reg[cand_id_reg], 2'b00};
  assign handler_addr = AddrWidth'(vec_word);

  // Stage 2 decision: return beats take; an empty-stack return only flags an error
  always_comb begin
    act_err  = 1'b0;
    act_tail = 1'b0;
    act_pop  = 1'b0;
    act_take = 1'b0;
    if (!reset) begin
      if (bus.ret_i) begin
        if (stack_empty)                              act_err  = 1'b1;
        else if (cand_qual && cand_prio_reg > top_th) act_tail = 1'b1;
        else                                          act_pop  = 1'b1;
      end else if (mie && cand_qual && cand_prio_reg > thresh_reg && !stack_full) begin
        act_take = 1'b1;
      end
    end
  end

  // PC redirect outputs for the chosen action
  always_comb begin
    bus.int_valid  = 1'b0;
    bus.tail_chain = 1'b0;
    bus.int_addr   = '0;
    bus.int_id     = '0;
    bus.int_prio   = '0;
    if (act_take || act_tail) begin
      bus.int_valid  = 1'b1;
      bus.tail_chain = act_tail;
      bus.int_addr   = handler_addr;
      bus.int_id     = cand_id_reg;
      bus.int_prio   = cand_prio_reg;
    end else if (act_pop) begin
      bus.int_valid  = 1'b1;
      bus.int_addr   = top_pc;
      bus.int_prio   = top_th;
    end
  end

  // CSR read mux; unmapped addresses read as zero
  always_comb begin
    bus.csr_rdata = '0;
    if (bus.csr_addr == ThreshAddr) bus.csr_rdata = 32'(thresh_reg);
    if (bus.csr_addr == LevelAddr)  bus.csr_rdata = 32'(level_reg);
    for (int i = 0; i < NumIrq; i++) begin
      if (bus.csr_addr == EntryBase + 12'(i))
        bus.csr_rdata = 32'({prio_reg[i], trig_reg[i], en_reg[i], pend_reg[i]});
      if (bus.csr_addr == VecBase + 12'(i))
        bus.csr_rdata = vec_reg[i];
    end
  end

  // Entry configuration, vector registers, pend bits and edge-detect history
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_reg  <= '0;
      en_reg    <= '0;
      trig_reg  <= '0;
      irq_q_reg <= '0;
      for (int i = 0; i < NumIrq; i++) begin
        prio_reg[i] <= '0;
        vec_reg[i]  <= '0;
      end
    end else begin
      irq_q_reg <= irq_i;
      pend_reg  <= pend_next;
      for (int i = 0; i < NumIrq; i++) begin
        if (entry_we[i]) begin
          en_reg[i]   <= bus.csr_wdata[1];
          trig_reg[i] <= bus.csr_wdata[2];
          prio_reg[i] <= bus.csr_wdata[3 +: PrioWidth];
        end
        if (vec_we[i]) vec_reg[i] <= bus.csr_wdata;
      end
    end
  end

  // Register the stage-1 winner so stage 2 sees it one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      cand_valid_reg <= 1'b0;
      cand_id_reg    <= '0;
      cand_prio_reg  <= '0;
    end else begin
      cand_valid_reg <= scan_found;
      cand_id_reg    <= scan_id;
      cand_prio_reg  <= scan_prio;
    end
  end

  // Threshold, return stack and sticky error; controller updates beat CSR writes
  always_ff @(posedge clk) begin
    if (reset) begin
      thresh_reg    <= '0;
      level_reg     <= '0;
      stack_err_reg <= 1'b0;
      for (int i = 0; i < NumLevels; i++) begin
        stk_pc_reg[i] <= '0;
        stk_th_reg[i] <= '0;
      end
    end else begin
      if (act_take) begin
        stk_pc_reg[push_idx] <= bus.pc_in;
        stk_th_reg[push_idx] <= thresh_reg;
        level_reg            <= level_reg + LvW'(1);
      end else if (act_pop) begin
        level_reg <= level_reg - LvW'(1);
      end
      if (act_take || act_tail) thresh_reg <= cand_prio_reg;
      else if (act_pop)         thresh_reg <= top_th;
      else if (thresh_we)       thresh_reg <= bus.csr_wdata[PrioWidth-1:0];
      if (act_err) stack_err_reg <= 1'b1;
    end
  end

  assign level_out = level_reg;
  assign stack_err = stack_err_reg;

endmodule

// File: tb/tb_n_clic_pipe.sv
// Bench for n_clic_pipe: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a queue-based model.
module tb_n_clic_pipe;
  localparam int NI = 16;
  localparam int NL = 2;
  localparam logic [11:0] EB = 12'hB00;
  localparam logic [11:0] VB = 12'hB40;
  localparam logic [11:0] TA = 12'h347;
  localparam logic [11:0] LA = 12'h350;

  logic          clk;
  logic          reset;
  logic [NI-1:0] irq_i;
  logic          mie;
  logic [1:0]    level_out;
  logic          stack_err;

  n_clic_pipe_if #(.NumIrq(NI), .PrioWidth(4), .AddrWidth(32)) bus ();

  n_clic_pipe #(.NumIrq(NI), .PrioWidth(4), .NumLevels(NL), .AddrWidth(32)) dut (
    .clk(clk), .reset(reset), .irq_i(irq_i), .mie(mie), .bus(bus),
    .level_out(level_out), .stack_err(stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  typedef struct { logic [31:0] pc; int th; } frame_t;
  bit          m_pend [NI];
  bit          m_en   [NI];
  bit          m_trig [NI];
  int          m_prio [NI];
  logic [31:0] m_vec  [NI];
  int          m_thresh;
  bit          m_err;
  logic [NI-1:0] m_q;
  bit          m_cv;
  int          m_cid, m_cp;
  frame_t      m_stk[$];

  // Last observed DUT outputs, for directed literal checks
  logic        obs_valid, obs_tail;
  logic [31:0] obs_addr, obs_rd;
  int          obs_id, obs_prio;
  int          f_id, f_prio;
  logic [31:0] f_addr;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_pend[i] = 0; m_en[i] = 0; m_trig[i] = 0; m_prio[i] = 0; m_vec[i] = '0;
    end
    m_thresh = 0; m_err = 0; m_q = '0; m_cv = 0; m_cid = 0; m_cp = 0;
    m_stk.delete();
  endtask

  function automatic logic [31:0] m_read(logic [11:0] a);
    logic [31:0] r;
    r = '0;
    if (a == TA) r = 32'(m_thresh);
    if (a == LA) r = 32'(m_stk.size());
    for (int i = 0; i < NI; i++) begin
      if (a == EB + 12'(i))
        r = 32'((m_prio[i] << 3) | (int'(m_trig[i]) << 2) | (int'(m_en[i]) << 1) | int'(m_pend[i]));
      if (a == VB + 12'(i)) r = m_vec[i];
    end
    return r;
  endfunction

  // One clock: check outputs against the model, then advance the model.
  // Entered at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic cycle();
    int act; bit q; int best; int bp;
    bit e_valid; logic [31:0] e_addr; int e_id, e_prio;
    bit hw; bit base;
    #3;
    obs_valid = bus.int_valid; obs_tail = bus.tail_chain; obs_addr = bus.int_addr;
    obs_id = int'(bus.int_id); obs_prio = int'(bus.int_prio); obs_rd = bus.csr_rdata;
    chk("csr_rdata", bus.csr_rdata, m_read(bus.csr_addr));
    if (reset) begin
      chk("int_valid_in_reset", bus.int_valid, 0);
      model_reset();
    end else begin
      act = 0;
      q = m_cv && m_en[m_cid] && m_pend[m_cid];
      if (bus.ret_i) begin
        if (m_stk.size() == 0)               act = 4;
        else if (q && m_cp > m_stk[$].th)    act = 2;
        else                                 act = 3;
      end else if (mie && q && m_cp > m_thresh && m_stk.size() < NL) act = 1;
      e_valid = (act >= 1 && act <= 3);
      e_addr = '0; e_id = 0; e_prio = 0;
      if (act == 1 || act == 2) begin
        e_addr = m_vec[m_cid] << 2; e_id = m_cid; e_prio = m_cp;
      end else if (act == 3) begin
        e_addr = m_stk[$].pc; e_prio = m_stk[$].th;
      end
      chk("int_valid", bus.int_valid, e_valid);
      chk("tail_chain", bus.tail_chain, act == 2);
      chk("level_out", level_out, m_stk.size());
      chk("stack_err", stack_err, m_err);
      if (e_valid) begin
        chk("int_addr", bus.int_addr, e_addr);
        chk("int_id", bus.int_id, e_id);
        chk("int_prio", bus.int_prio, e_prio);
      end
      // highest priority among enabled+pended, lowest index on ties
      best = -1; bp = 0;
      for (int i = 0; i < NI; i++)
        if (m_en[i] && m_pend[i] && (best < 0 || m_prio[i] > bp)) begin best = i; bp = m_prio[i]; end
      // controller state
      if (act == 1) m_stk.push_back('{pc: bus.pc_in, th: m_thresh});
      if (act == 1 || act == 2) m_thresh = m_cp;
      else if (act == 3) begin m_thresh = m_stk[$].th; void'(m_stk.pop_back()); end
      else if (bus.csr_we && bus.csr_addr == TA) m_thresh = int'(bus.csr_wdata[3:0]);
      if (act == 4) m_err = 1;
      // entries
      for (int i = 0; i < NI; i++) begin
        hw = m_trig[i] ? (irq_i[i] && !m_q[i]) : irq_i[i];
        base = (bus.csr_we && bus.csr_addr == EB + 12'(i)) ? bus.csr_wdata[0] : m_pend[i];
        if ((act == 1 || act == 2) && i == m_cid) base = 0;
        m_pend[i] = hw | base;
        if (bus.csr_we && bus.csr_addr == EB + 12'(i)) begin
          m_en[i] = bus.csr_wdata[1]; m_trig[i] = bus.csr_wdata[2]; m_prio[i] = int'(bus.csr_wdata[6:3]);
        end
        if (bus.csr_we && bus.csr_addr == VB + 12'(i)) m_vec[i] = bus.csr_wdata;
      end
      m_q = irq_i;
      m_cv = (best >= 0); m_cid = (best >= 0) ? best : 0; m_cp = bp;
      $display("cyc t=%0t act=%0d valid=%0b id=%0d addr=%0h lvl=%0d", $time, act, bus.int_valid, bus.int_id, bus.int_addr, level_out);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) cycle();
  endtask

  task automatic wr(logic [11:0] a, logic [31:0] d);
    bus.csr_we = 1'b1; bus.csr_addr = a; bus.csr_wdata = d;
    cycle();
    bus.csr_we = 1'b0;
  endtask

  // run n cycles; count redirects and remember the first one
  task automatic run(int n, output int cnt, output int first, input int rd_at, output logic [31:0] rd);
    cnt = 0; first = -1; rd = '0;
    for (int k = 0; k < n; k++) begin
      cycle();
      if (k == rd_at) rd = obs_rd;
      if (obs_valid) begin
        cnt++;
        if (first < 0) begin first = k; f_id = obs_id; f_addr = obs_addr; f_prio = obs_prio; end
      end
    end
  endtask

  task automatic do_ret();
    bus.ret_i = 1'b1;
    cycle();
    bus.ret_i = 1'b0;
  endtask

  initial begin
    int cnt, first, r;
    logic [31:0] rd;
    reset = 1'b1; irq_i = '0; mie = 1'b1;
    bus.csr_we = 1'b0; bus.csr_addr = '0; bus.csr_wdata = '0; bus.pc_in = 32'h100; bus.ret_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    bus.csr_addr = TA;
    #1;
    chk("reset_level", level_out, 0);
    chk("reset_stack_err", stack_err, 0);
    chk("reset_int_valid", bus.int_valid, 0);
    chk("reset_thresh", bus.csr_rdata, 0);

    // Edge latency: irq3 edge, prio 5
    wr(EB + 12'd3, 32'h2E);
    wr(VB + 12'd3, 32'h1000);
    bus.csr_addr = EB + 12'd3;
    irq_i[3] = 1'b1;
    run(6, cnt, first, 3, rd);
    chk("edge_latency", first, 2);
    chk("edge_take_count", cnt, 1);
    chk("edge_id", f_id, 3);
    chk("edge_addr", f_addr, 32'h4000);
    chk("edge_prio", f_prio, 5);
    chk("edge_pend_cleared", rd, 32'h2E);
    chk("edge_level", level_out, 1);

    // Preemption by prio 9, then a same-prio pend that must not preempt
    bus.pc_in = 32'h200;
    wr(EB + 12'd7, 32'h4F);
    wr(VB + 12'd7, 32'h2000);
    run(5, cnt, first, 0, rd);
    chk("preempt_count", cnt, 1);
    chk("preempt_id", f_id, 7);
    chk("preempt_addr", f_addr, 32'h8000);
    chk("preempt_level", level_out, 2);
    wr(EB + 12'd2, 32'h2F);
    run(5, cnt, first, 0, rd);
    chk("no_preempt_equal_prio", cnt, 0);
    wr(EB + 12'd2, 32'h0);
    idle(2);
    do_ret();
    chk("ret1_valid", obs_valid, 1);
    chk("ret1_addr", obs_addr, 32'h200);
    chk("ret1_prio", obs_prio, 5);
    idle(1);
    do_ret();
    chk("ret2_addr", obs_addr, 32'h100);
    chk("ret2_prio", obs_prio, 0);
    chk("ret2_level", level_out, 0);

    // Tail-chain: re-enter irq3, pend irq1 prio 2, return chains into it
    irq_i[3] = 1'b0;
    cycle();
    irq_i[3] = 1'b1;
    bus.pc_in = 32'h100;
    run(4, cnt, first, 0, rd);
    chk("tc_take", cnt, 1);
    wr(EB + 12'd1, 32'h17);
    wr(VB + 12'd1, 32'h3000);
    idle(2);
    do_ret();
    chk("tc_tail", obs_tail, 1);
    chk("tc_id", obs_id, 1);
    chk("tc_prio", obs_prio, 2);
    chk("tc_addr", obs_addr, 32'hC000);
    chk("tc_level", level_out, 1);
    idle(1);
    do_ret();
    chk("tc_pop_addr", obs_addr, 32'h100);
    chk("tc_pop_level", level_out, 0);

    // Level mode: take, re-pend while high, tail-chain, then plain return
    wr(EB + 12'd4, 32'h1A);
    wr(VB + 12'd4, 32'h4000);
    bus.csr_addr = EB + 12'd4;
    irq_i[4] = 1'b1;
    run(4, cnt, first, 3, rd);
    chk("lvl_take_id", f_id, 4);
    chk("lvl_repend", rd, 32'h1B);
    irq_i[4] = 1'b0;
    do_ret();
    chk("lvl_tail", obs_tail, 1);
    chk("lvl_tail_id", obs_id, 4);
    idle(2);
    do_ret();
    chk("lvl_plain_tail", obs_tail, 0);
    chk("lvl_plain_addr", obs_addr, 32'h100);

    // Saturation at depth 2
    bus.pc_in = 32'h300;
    wr(EB + 12'd8, 32'h27);
    idle(4);
    chk("sat_level1", level_out, 1);
    bus.pc_in = 32'h400;
    wr(EB + 12'd9, 32'h37);
    idle(4);
    chk("sat_level2", level_out, 2);
    wr(EB + 12'd10, 32'h47);
    run(5, cnt, first, 0, rd);
    chk("sat_no_take", cnt, 0);
    bus.csr_addr = EB + 12'd10;
    cycle();
    chk("sat_held_pend", obs_rd, 32'h47);
    do_ret();
    chk("sat_tail", obs_tail, 1);
    chk("sat_tail_id", obs_id, 10);
    chk("sat_tail_level", level_out, 2);
    idle(1);
    do_ret();
    chk("sat_pop1_addr", obs_addr, 32'h400);
    chk("sat_pop1_prio", obs_prio, 4);
    idle(1);
    do_ret();
    chk("sat_pop2_addr", obs_addr, 32'h300);
    idle(1);
    do_ret();
    chk("empty_ret_valid", obs_valid, 0);
    idle(3);
    chk("stack_err_sticky", stack_err, 1);

    // Tie to lowest index, then stale candidate dropped
    wr(EB + 12'd2, 32'h3E);
    wr(EB + 12'd5, 32'h3E);
    bus.pc_in = 32'h500;
    irq_i[2] = 1'b1; irq_i[5] = 1'b1;
    run(4, cnt, first, 0, rd);
    chk("tie_id", f_id, 2);
    wr(EB + 12'd5, 32'h3E);
    do_ret();
    chk("stale_tail", obs_tail, 0);
    chk("stale_addr", obs_addr, 32'h500);

    // Reset mid-handler
    wr(EB + 12'd5, 32'h3F);
    idle(3);
    chk("pre_reset_level", level_out, 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("post_reset_level", level_out, 0);
    chk("post_reset_err", stack_err, 0);
    chk("post_reset_valid", bus.int_valid, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      irq_i = irq_i ^ NI'($urandom & $urandom & $urandom);
      mie = ($urandom % 10) != 0;
      bus.ret_i = ($urandom % 8) == 0;
      bus.pc_in = $urandom & 32'hFFFF_FFFC;
      bus.csr_we = ($urandom % 4) == 0;
      bus.csr_wdata = $urandom;
      r = $urandom % 10;
      if (r < 5)       bus.csr_addr = EB + 12'($urandom_range(0, NI - 1));
      else if (r < 7)  bus.csr_addr = VB + 12'($urandom_range(0, NI - 1));
      else if (r == 7) bus.csr_addr = TA;
      else if (r == 8) bus.csr_addr = LA;
      else             bus.csr_addr = 12'($urandom);
      reset = ($urandom % 500) == 0;
      cycle();
    end
    reset = 1'b0; bus.csr_we = 1'b0; bus.ret_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/n_clic_pipe.md
Name: n_clic_pipe

Overview:
Parametrised, pipelined successor to the core-local interrupt controller. It accepts NumIrq external interrupt lines, each individually configurable as level- or edge-triggered. Arbitration runs through one registered stage so the priority scan is off the PC critical path. Nested preemption and tail-chaining use a bounded return stack of depth NumLevels; the block sits beside the CSR file and drives the PC interrupt mux.

Parameters:
NumIrq, 16, number of interrupt sources/vectors (2..64)
PrioWidth, 4, priority bits per vector; threshold width
NumLevels, 8, return-stack depth (max nesting)
AddrWidth, 32, PC/handler address width
EntryBase, 12'hB00, CSR address of entry 0 (entry k at EntryBase+k)
VecBase, 12'hB40, CSR address of handler word-address register 0
ThreshAddr, 12'h347, CSR address of threshold
LevelAddr, 12'h350, CSR address of stack depth (read-only)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
irq_i  in  NumIrq  raw interrupt lines, synchronous to clk
mie  in  1  global interrupt enable
csr_we  in  1  CSR write strobe
csr_addr  in  12  CSR address
csr_wdata  in  32  CSR write data
csr_rdata  out  32  CSR read data, combinational on csr_addr
pc_in  in  AddrWidth  current PC, pushed on take
ret_i  in  1  handler-return strobe, one cycle
int_valid  out  1  redirect PC this cycle (take, tail-chain or return)
int_addr  out  AddrWidth  redirect target
int_id  out  $clog2(NumIrq)  vector being entered
int_prio  out  PrioWidth  new threshold
tail_chain  out  1  redirect is a tail-chain
level_out  out  $clog2(NumLevels+1)  current stack depth
stack_err  out  1  sticky: return on empty stack

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset. Reset clears all entries (pended/enabled/trig/prio = 0), vector registers, threshold, stack, irq_q, candidate register and stack_err. All outputs reset to 0.
- Entry CSR layout: bit0 pended, bit1 enabled, bit2 trig (0 level, 1 edge), bits[3+:PrioWidth] prio. Other bits read 0.
- Vector CSR: holds the handler word address. int_addr = {vec, 2'b00}, truncated to AddrWidth.
- Pend set, edge mode: irq_q <= irq_i every cycle; irq_i & ~irq_q sets pended at the next clk.
- Pend set, level mode: pended is set every cycle irq_i is high. A take clears it, and it re-pends the next cycle if the line is still high.
- Pend conflicts in the same cycle: hardware set beats CSR write-0 and beats take-clear.
- Stage 1, combinational scan: find the highest prio among enabled && pended entries. Ties go to the lowest index.
- Stage 1 result is registered into cand_valid/cand_id/cand_prio, so a candidate reflects pend state one cycle old.
- Stage 2 qualification: the registered candidate is acted on only if entry[cand_id] is still enabled && pended this cycle. A stale candidate is dropped without action.
- Priority order per cycle: return > take > idle.
- Return (ret_i=1), tail-chain case: a qualified candidate exists with cand_prio > stack top's saved threshold.
  - No push/pop; thresh <= cand_prio; clear pend.
  - int_valid=1, tail_chain=1, int_addr = handler.
- Return (ret_i=1), plain return: otherwise pop.
  - thresh <= saved threshold; int_addr = saved PC.
  - int_valid=1, int_id=0.
- Return on empty stack: no state change except stack_err <= 1. int_valid=0.
- Take (ret_i=0): mie=1, qualified candidate, cand_prio > thresh, and level_out < NumLevels.
  - Push {pc_in, thresh}; thresh <= cand_prio; clear pend.
  - int_valid=1, int_addr = handler, int_id = cand_id, int_prio = cand_prio.
- Stack full: takes are inhibited and pends held. Returns and tail-chains still work.
- mie=0: no take. A return still pops and tail-chain still applies.
- Latency: an edge irq rising in cycle 0 gives int_valid in cycle 2.
- CSR writes: take effect at the next clk. A CSR write to thresh in the same cycle as a take/return/tail-chain loses to the controller update. Writes to LevelAddr are ignored. Unmapped reads return 0.

Test Plan:
- Edge latency: irq 3 edge-mode, enabled, prio 5, thresh 0, mie=1, pc_in=0x100, irq_i[3] rises cycle 0 -> cycle 2 int_valid=1, int_id=3, int_addr={vec3,2'b00}, int_prio=5, level_out=1. Entry3 pended=0 in cycle 3; irq held high causes no second take.
- Preemption: while in prio-5 handler, pend irq 7 prio 9 -> take, level_out=2. Pend irq 2 prio 5 -> no take. Two ret_i -> first pops to prio 5; second pops to thresh 0, int_addr=0x100.
- Tail-chain: in irq3 (prio 5, saved thresh 0), irq 1 prio 2 pended, ret_i -> tail_chain=1, int_id=1, int_prio=2, level_out stays 1.
- Level mode: irq 4 level, prio 3, line held high -> take, pend re-set next cycle. After ret_i: tail-chain to irq 4. Line dropped before ret_i -> plain return.
- Saturation: NumLevels=2, three increasing priorities pended -> only two takes, third stays pended until a ret_i. ret_i at level 0 -> stack_err=1 and stays 1 until reset.
- Tie, stale and reset: irq 2 and 5 same prio pended together -> id 2 first. CSR-clear pend of 5 the cycle before its candidate acts -> no take. reset mid-handler -> all outputs 0, level_out=0.
